// File: rtl/but_pkg.sv
// Shared definitions for the push-button conditioner: per-button FSM encoding,
// default timing constants for the 12 MHz board clock and a counter-width helper.
package but_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } but_state_t;

    localparam int BUT_DEBOUNCE_CYCLES_DFLT = 240000;   // 20 ms at 12 MHz
    localparam int BUT_REPEAT_DELAY_DFLT    = 6000000;  // 500 ms at 12 MHz
    localparam int BUT_REPEAT_PERIOD_DFLT   = 1200000;  // 100 ms at 12 MHz

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/but_debounce_chan.sv
// One button channel: 2-flop synchronizer, polarity fold, stability counter,
// four-state FSM and registered press/release strobes.
// Optional autorepeat timer is built only when BUT_AUTOREPEAT_EN is defined;
// otherwise rpt is tied low.
//
// state           | meaning
// ST_RELEASED     | level 0, sample agrees with level
// ST_PRESS_PEND   | level 0, counting consecutive pressed samples
// ST_HELD         | level 1, sample agrees with level (repeat timer runs)
// ST_RELEASE_PEND | level 1, counting consecutive released samples
module but_debounce_chan
    import but_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BUT_DEBOUNCE_CYCLES_DFLT,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = BUT_REPEAT_DELAY_DFLT,
    parameter int REPEAT_PERIOD   = BUT_REPEAT_PERIOD_DFLT
) (
    input  logic clk,
    input  logic rstn,
    input  logic but,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a, sync_b;
    logic          sample;
    logic          differs;
    logic          done;
    but_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          press_q, rel_q;
    logic          press_nxt, rel_nxt;

    // Synchronizer resets to the released pin value so reset never looks like a press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_a <= ACTIVE_LOW;
            sync_b <= ACTIVE_LOW;
        end else begin
            sync_a <= but;
            sync_b <= sync_a;
        end
    end

    assign sample  = sync_b ^ ACTIVE_LOW;
    assign differs = sample ^ state[1];
    assign done    = differs && (cnt == CNT_LAST);

    // State register: FSM, stability counter and registered strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_RELEASED;
            cnt     <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            press_q <= press_nxt;
            rel_q   <= rel_nxt;
        end
    end

    // Next state: any sample agreeing with the level drops the pending count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (!differs || done) ? '0 : cnt + 1'b1;
        case (state)
            ST_RELEASED:     if (differs) state_nxt = ST_PRESS_PEND;
            ST_PRESS_PEND:   if (!differs) state_nxt = ST_RELEASED;
                             else if (done) state_nxt = ST_HELD;
            ST_HELD:         if (differs) state_nxt = ST_RELEASE_PEND;
            ST_RELEASE_PEND: if (!differs) state_nxt = ST_HELD;
                             else if (done) state_nxt = ST_RELEASED;
            default:         state_nxt = ST_RELEASED;
        endcase
    end

    // Output decode: strobes fire on the edge where the level flips.
    always_comb begin
        press_nxt = (state == ST_PRESS_PEND)   && (state_nxt == ST_HELD);
        rel_nxt   = (state == ST_RELEASE_PEND) && (state_nxt == ST_RELEASED);
    end

    assign level = state[1];
    assign press = press_q;
    assign rel   = rel_q;

`ifdef BUT_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_width(RPT_MAX);
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt, rpt_cnt_nxt;
    logic          rpt_q, rpt_nxt;

    // Repeat timer: down-counter loaded on entry to HELD, reloaded at each repeat,
    // held at zero whenever the button is not in HELD.
    always_comb begin
        rpt_cnt_nxt = '0;
        if (state_nxt == ST_HELD) begin
            if (state == ST_PRESS_PEND)
                rpt_cnt_nxt = RPT_FIRST;
            else if (state == ST_RELEASE_PEND)
                rpt_cnt_nxt = RPT_NEXT;
            else if (rpt_cnt == '0)
                rpt_cnt_nxt = RPT_NEXT;
            else
                rpt_cnt_nxt = rpt_cnt - 1'b1;
        end
        rpt_nxt = (state == ST_HELD) && (rpt_cnt == '0);
    end

    // Repeat timer and strobe registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rpt_cnt <= '0;
            rpt_q   <= 1'b0;
        end else begin
            rpt_cnt <= rpt_cnt_nxt;
            rpt_q   <= rpt_nxt;
        end
    end

    assign rpt = rpt_q;
`else
    // Repeat timing has no effect in this build; the parameters remain for a uniform interface.
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_rpt_unused
    end

    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/but_conditioner.sv
// Push-button conditioner top: N independent debounce channels.
// Define BUT_AUTOREPEAT_EN to build the autorepeat timers; without it
// but_repeat is constant 0.
module but_conditioner
    import but_pkg::*;
#(
    parameter int N               = 2,
    parameter int DEBOUNCE_CYCLES = BUT_DEBOUNCE_CYCLES_DFLT,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = BUT_REPEAT_DELAY_DFLT,
    parameter int REPEAT_PERIOD   = BUT_REPEAT_PERIOD_DFLT
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] but,
    output logic [N-1:0] but_level,
    output logic [N-1:0] but_press,
    output logic [N-1:0] but_release,
    output logic [N-1:0] but_repeat
);

    for (genvar i = 0; i < N; i++) begin : g_chan
        but_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk   (clk),
            .rstn  (rstn),
            .but   (but[i]),
            .level (but_level[i]),
            .press (but_press[i]),
            .rel   (but_release[i]),
            .rpt   (but_repeat[i])
        );
    end

endmodule

// File: tb/tb_but_conditioner.sv
// Self-checking bench for but_conditioner: directed scenarios plus random
// button activity, checked by a window-based reference model through a
// per-cycle scoreboard queue.
module tb_but_conditioner;

    localparam int N    = 2;
    localparam int DEB  = 8;
    localparam int RDLY = 20;
    localparam int RPER = 5;
    localparam bit AL   = 1'b1;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] but;
    logic [N-1:0] but_level, but_press, but_release, but_repeat;

    always #5 clk = ~clk;

    but_conditioner #(
        .N               (N),
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (AL),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .but         (but),
        .but_level   (but_level),
        .but_press   (but_press),
        .but_release (but_release),
        .but_repeat  (but_repeat)
    );

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] rep;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    // Reference model: a level flips once the last DEB samples (raw delayed by
    // two edges) all disagree with it; repeats follow arithmetic schedules.
    logic [N-1:0] hist[$];
    logic [N-1:0] m_lvl, m_samp, m_samp_prev;
    int           m_next_rep[N];
    int           t_edge;
    exp_t         m_e;
    bit           m_diff, m_was_held, m_was_relpend;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist.delete();
            for (int i = 0; i < DEB + 2; i++) hist.push_back('0);
            m_lvl       = '0;
            m_samp_prev = '0;
            for (int b = 0; b < N; b++) m_next_rep[b] = -1;
            t_edge = 0;
            exp_q.delete();
        end else begin
            hist.push_back(but ^ {N{AL}});
            void'(hist.pop_front());
            m_samp = hist[DEB-1];
            m_e    = '0;
            for (int b = 0; b < N; b++) begin
                m_diff = 1'b1;
                for (int i = 0; i < DEB; i++)
                    if (hist[i][b] == m_lvl[b]) m_diff = 1'b0;
                m_was_held    = m_lvl[b] && m_samp_prev[b];
                m_was_relpend = m_lvl[b] && !m_samp_prev[b];
                if (m_diff) begin
                    m_e.press[b] = !m_lvl[b];
                    m_e.rel[b]   = m_lvl[b];
                    m_lvl[b]     = !m_lvl[b];
                end
`ifdef BUT_AUTOREPEAT_EN
                if (m_was_held && t_edge == m_next_rep[b]) begin
                    m_e.rep[b]    = 1'b1;
                    m_next_rep[b] = m_next_rep[b] + RPER;
                end
                if (m_e.press[b])
                    m_next_rep[b] = t_edge + RDLY;
                else if (m_was_relpend && m_lvl[b] && m_samp[b])
                    m_next_rep[b] = t_edge + RPER;
                if (!(m_lvl[b] && m_samp[b]))
                    m_next_rep[b] = -1;
`endif
            end
            m_e.lvl     = m_lvl;
            m_samp_prev = m_samp;
            exp_q.push_back(m_e);
            t_edge++;
        end
    end

    // Monitor: pops one expectation per cycle and compares on the falling edge.
    int   cnt_press[N];
    int   cnt_rel[N];
    int   cnt_rep[N];
    exp_t mon_e;

    initial for (int b = 0; b < N; b++) begin
        cnt_press[b] = 0;
        cnt_rel[b]   = 0;
        cnt_rep[b]   = 0;
    end

    always @(negedge clk) begin
        if (!rstn) begin
            check("reset_outputs", 32'({but_level, but_press, but_release, but_repeat}), 32'd0);
        end else if (exp_q.size() == 0) begin
            if (t_edge == 0) begin
                check("idle_after_reset", 32'({but_level, but_press, but_release, but_repeat}), 32'd0);
            end else begin
                n_checks++;
                $display("FAIL scoreboard_underflow: no expectation at %0t", $time);
            end
        end else begin
            mon_e = exp_q.pop_front();
            check("sb_level",   32'(but_level),   32'(mon_e.lvl));
            check("sb_press",   32'(but_press),   32'(mon_e.press));
            check("sb_release", 32'(but_release), 32'(mon_e.rel));
            check("sb_repeat",  32'(but_repeat),  32'(mon_e.rep));
        end
        for (int b = 0; b < N; b++) begin
            cnt_press[b] += int'(but_press[b]);
            cnt_rel[b]   += int'(but_release[b]);
            cnt_rep[b]   += int'(but_repeat[b]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int pb, pr, p1, r1, rp;

    initial begin
        rstn = 1'b1;
        but  = '1;
        #1 rstn = 1'b0;
        step(3);
        rstn = 1'b1;
        step(3);

        // Clean press and release on button 0
        but[0] = 1'b0;
        step(9);
        check("clean_press_early", 32'(but_press[0]), 32'd0);
        step(1);
        check("clean_press_strobe", 32'(but_press[0]), 32'd1);
        check("clean_press_level", 32'(but_level[0]), 32'd1);
        step(1);
        check("clean_press_width", 32'(but_press[0]), 32'd0);
        but[0] = 1'b1;
        step(9);
        check("clean_release_early", 32'(but_release[0]), 32'd0);
        step(1);
        check("clean_release_strobe", 32'(but_release[0]), 32'd1);
        check("clean_release_level", 32'(but_level[0]), 32'd0);
        step(5);

        // Bounce: toggle every 3 cycles, finally settle pressed
        pb = cnt_press[0];
        for (int k = 0; k < 10; k++) begin
            but[0] = k[0];
            step(3);
        end
        but[0] = 1'b0;
        step(9);
        check("bounce_press_early", 32'(but_press[0]), 32'd0);
        step(1);
        check("bounce_press_strobe", 32'(but_press[0]), 32'd1);
        step(2);
        check("bounce_single_press", 32'(cnt_press[0] - pb), 32'd1);
        but[0] = 1'b1;
        step(15);

        // Glitch on button 1 shorter than the debounce window
        p1 = cnt_press[1];
        r1 = cnt_rel[1];
        but[1] = 1'b0;
        step(5);
        but[1] = 1'b1;
        step(15);
        check("glitch_level", 32'(but_level[1]), 32'd0);
        check("glitch_no_press", 32'(cnt_press[1] - p1), 32'd0);
        check("glitch_no_release", 32'(cnt_rel[1] - r1), 32'd0);

        // Simultaneous press and release
        but = 2'b00;
        step(10);
        check("simul_press", 32'(but_press), 32'd3);
        step(40);
        but = 2'b11;
        step(10);
        check("simul_release", 32'(but_release), 32'd3);
        step(5);

        // Reset during a pending press, button held through reset release
        pb = cnt_press[0];
        but[0] = 1'b0;
        step(7);
        rstn = 1'b0;
        step(1);
        check("midreset_outputs", 32'({but_level, but_press, but_release, but_repeat}), 32'd0);
        step(2);
        rstn = 1'b1;
        step(9);
        check("midreset_press_early", 32'(but_press[0]), 32'd0);
        step(1);
        check("midreset_press_strobe", 32'(but_press[0]), 32'd1);
        step(2);
        check("midreset_single_press", 32'(cnt_press[0] - pb), 32'd1);
        but[0] = 1'b1;
        step(15);

`ifdef BUT_AUTOREPEAT_EN
        // Autorepeat while held for 50 cycles after the press strobe
        but[0] = 1'b0;
        step(10);
        check("rpt_press_strobe", 32'(but_press[0]), 32'd1);
        check("rpt_not_with_press", 32'(but_repeat[0]), 32'd0);
        rp = cnt_rep[0];
        step(19);
        check("rpt_first_early", 32'(but_repeat[0]), 32'd0);
        step(1);
        check("rpt_first", 32'(but_repeat[0]), 32'd1);
        step(30);
        check("rpt_last", 32'(but_repeat[0]), 32'd1);
        but[0] = 1'b1;
        step(20);
        check("rpt_count", 32'(cnt_rep[0] - rp), 32'd7);
`else
        but[0] = 1'b0;
        step(60);
        but[0] = 1'b1;
        step(15);
`endif

        // Random activity on both buttons, one reset in the middle
        for (int seg = 0; seg < 200; seg++) begin
            but = N'($urandom);
            step(int'($urandom_range(1, 14)));
            if (seg == 100) begin
                rstn = 1'b0;
                step(2);
                rstn = 1'b1;
            end
        end
        but = '1;
        step(30);
        check("final_level", 32'(but_level), 32'd0);
`ifndef BUT_AUTOREPEAT_EN
        check("no_repeat", 32'(cnt_rep[0] + cnt_rep[1]), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/but_conditioner.md
# but_conditioner

Input conditioner for the board push buttons: synchronizes each raw button pin to the system clock, filters contact bounce with a per-button stability counter, and produces a clean level plus single-cycle press/release strobes. It sits between the button pins and any logic that consumes button events, such as the LED drivers. It is the input-side counterpart of the LED output path.

## Interface
- `N`, 2, number of buttons
- `DEBOUNCE_CYCLES`, 240000, consecutive stable samples required to accept a change (20 ms at 12 MHz); must be ≥2
- `ACTIVE_LOW`, 1, 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed
- `REPEAT_DELAY`, 6000000, cycles from press strobe to first repeat strobe (used only with autorepeat)
- `REPEAT_PERIOD`, 1200000, cycles between subsequent repeat strobes (used only with autorepeat)
- `clk` in 1 system clock, all logic on rising edge
- `rstn` in 1 asynchronous active-low reset
- `but` in N raw button pins, asynchronous to `clk`
- `but_level` out N debounced state, 1 = pressed
- `but_press` out N one-cycle strobe on accepted press
- `but_release` out N one-cycle strobe on accepted release
- `but_repeat` out N one-cycle autorepeat strobe while held

## Operation
- Per button: 2-flop synchronizer, then polarity fold (`pressed = sync ^ ACTIVE_LOW`).
- Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- If the sample equals `but_level`, the counter clears.
- If the sample differs and the counter is below `DEBOUNCE_CYCLES-1`, the counter increments.
- If the sample differs and the counter equals `DEBOUNCE_CYCLES-1`, `but_level` toggles on the next edge and the counter clears.
- Per-button FSM: RELEASED, PRESS_PEND (counting toward press), HELD, RELEASE_PEND (counting toward release).
  - PRESS_PEND falls back to RELEASED if the sample reverts before the count completes.
  - RELEASE_PEND falls back to HELD on revert.
  - Each revert clears the counter; there is no partial credit.
- `but_press` is high exactly on the cycle `but_level` first reads 1.
- `but_release` is high exactly on the cycle `but_level` first reads 0.
- Buttons are fully independent. Simultaneous events on different buttons each produce their own strobes in the same cycle.
- Reset values:
  - `but_level`, `but_press`, `but_release`, `but_repeat`, counters and FSMs: 0 / RELEASED.
  - Synchronizer flops: the released pin value (`ACTIVE_LOW`).
- A button held through reset deassertion yields a normal press after full latency.
- Reset asserted mid-count aborts the count with no strobe.

## Timing
- Press latency from a raw edge to `but_press`/`but_level` rising is 2 sync cycles plus `DEBOUNCE_CYCLES` cycles. Release latency is identical.
- A raw pulse or glitch shorter than `DEBOUNCE_CYCLES` sampled cycles produces no output change.
- Strobes are exactly one cycle wide. A new strobe on the same button needs at least `DEBOUNCE_CYCLES` cycles.
- All outputs are registered, with no combinational path from `but`.

## Configuration
- `BUT_AUTOREPEAT_EN` defined:
  - While HELD, a repeat timer starts at the press strobe.
  - `but_repeat` pulses `REPEAT_DELAY` cycles after `but_press`, then every `REPEAT_PERIOD` cycles.
  - Leaving HELD (entering RELEASE_PEND) stops and clears the timer. A release that reverts back to HELD restarts the timer at `REPEAT_PERIOD`.
  - `but_repeat` never coincides with `but_press`.
- `BUT_AUTOREPEAT_EN` undefined:
  - Timer logic is absent and `but_repeat` is tied to 0.
  - `REPEAT_*` parameters are ignored.

## Structure
- Shared package `but_pkg`:
  - FSM state encoding (2-bit: RELEASED=0, PRESS_PEND=1, HELD=2, RELEASE_PEND=3).
  - Default timing constants for the 12 MHz board clock.
- Sub-module `but_debounce_chan` holds one button's synchronizer, counter, FSM and optional repeat timer. The top instantiates it `N` times in a generate loop.

## Test plan
Benches use `DEBOUNCE_CYCLES=8`, `REPEAT_DELAY=20`, `REPEAT_PERIOD=5`, `ACTIVE_LOW=1`.
- Clean press: `but[0]` 1→0 and held. Required: `but_press[0]` pulses 10 cycles later for one cycle, and `but_level[0]`=1 from that cycle.
- Bounce: `but[0]` toggles every 3 cycles for 30 cycles, then holds 0. Required: exactly one `but_press[0]`, at 10 cycles after the last toggle.
- Glitch: `but[1]` low for 5 cycles, then high. Required: no strobes, and `but_level[1]` stays 0.
- Simultaneous: both buttons pressed in the same cycle, then released together 50 cycles later. Required: `but_press`=2'b11 in one cycle and `but_release`=2'b11 in one cycle.
- Reset mid-count: press `but[0]`, assert `rstn`=0 at count 5, release reset with the button still held. Required: all outputs 0 during reset, and a press strobe 10 cycles after reset release.
- Autorepeat (macro defined): hold `but[0]` for 50 cycles after the press strobe. Required: `but_repeat[0]` at +20, +25, …, +50, and none after release begins. With the macro undefined, `but_repeat` stays 0.
